addsub_sequencer: RTL and testbench

Multi-byte add/subtract controller. It sequences one shared 8-bit ripple-carry byte adder over a `BYTES`-wide operand pair, one byte per clock, least-significant byte first. The carry is chained through a register between bytes. The block sits between the command source and the byte adder, and turns the byte datapath into a wide arithmetic unit with a start/busy/done handshake.

---
 rtl/addsub_sequencer.sv | 160 ++++++++++++++++
 tb/tb_addsub_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/addsub_sequencer.sv
// Multi-byte add/subtract controller: one shared 8-bit ripple adder walked LSB-first
// over BYTES bytes, carry chained through a register. Optional ADDSUB_OVERFLOW_EN adds `overflow`.
module addsub_sequencer #(
   parameter int BYTES = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 sub,
   input  logic [8*BYTES-1:0]   A,
   input  logic [8*BYTES-1:0]   B,
   output logic                 busy,
   output logic                 done,
   output logic [8*BYTES-1:0]   result,
   output logic                 cout,
   output logic                 zero
`ifdef ADDSUB_OVERFLOW_EN
   ,
   output logic                 overflow
`endif
);

   localparam int W = 8 * BYTES;
   localparam logic [2:0] LAST_IDX = 3'(BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [2:0]     idx_q, idx_d;
   logic           carry_q, carry_d;
   logic           sub_q, sub_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   result_q, result_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           cout_q, cout_d;
   logic           zero_q, zero_d;
`ifdef ADDSUB_OVERFLOW_EN
   logic           ovf_q, ovf_d;
`endif

   // The single byte adder: explicit ripple so the carry into bit 7 is visible.
   logic [7:0]     byte_a;
   logic [7:0]     byte_b;
   logic [7:0]     byte_sum;
   logic [8:0]     chain;

   always_comb begin
      byte_a   = a_q[8*idx_q +: 8];
      byte_b   = b_q[8*idx_q +: 8] ^ {8{sub_q}};
      chain    = '0;
      byte_sum = '0;
      chain[0] = carry_q;
      for (int i = 0; i < 8; i++) begin
         byte_sum[i]  = byte_a[i] ^ byte_b[i] ^ chain[i];
         chain[i+1]   = (byte_a[i] & byte_b[i]) | (chain[i] & (byte_a[i] ^ byte_b[i]));
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      sub_d    = sub_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      done_d   = 1'b0;
      cout_d   = cout_q;
      zero_d   = zero_q;
`ifdef ADDSUB_OVERFLOW_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               sub_d   = sub;
               idx_d   = 3'd0;
               carry_d = sub;
               cout_d  = 1'b0;
               zero_d  = 1'b0;
`ifdef ADDSUB_OVERFLOW_EN
               ovf_d   = 1'b0;
`endif
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            result_d[8*idx_q +: 8] = byte_sum;
            carry_d = chain[8];
            idx_d   = idx_q + 3'd1;
            if (idx_q == LAST_IDX) begin
`ifdef ADDSUB_OVERFLOW_EN
               ovf_d = chain[7] ^ chain[8];
`endif
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            cout_d  = carry_q;
            zero_d  = (result_q == '0);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         sub_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
`ifdef ADDSUB_OVERFLOW_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         sub_q    <= sub_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cout_q   <= cout_d;
         zero_q   <= zero_d;
`ifdef ADDSUB_OVERFLOW_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign cout   = cout_q;
   assign zero   = zero_q;
`ifdef ADDSUB_OVERFLOW_EN
   assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_sequencer.sv
// Bench for addsub_sequencer (BYTES=4): directed corner cases plus random operations
// scored against a plain-arithmetic reference model. Honours ADDSUB_OVERFLOW_EN.
module tb_addsub_sequencer;

   localparam int BYTES = 4;
   localparam int W     = 8 * BYTES;

   logic           clock;
   logic           reset;
   logic           start;
   logic           sub;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic           busy;
   logic           done;
   logic [W-1:0]   result;
   logic           cout;
   logic           zero;
`ifdef ADDSUB_OVERFLOW_EN
   logic           overflow;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Expected {overflow, cout, result}, pushed at start, popped at done.
   logic [W+1:0] exp_q[$];

   addsub_sequencer #(.BYTES(BYTES)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .sub     (sub),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .cout    (cout),
      .zero    (zero)
`ifdef ADDSUB_OVERFLOW_EN
      ,
      .overflow(overflow)
`endif
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: wide modular arithmetic, subtract as A + ~B + 1, textbook signed overflow.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
      logic [W:0]   full;
      logic [W-1:0] r;
      logic         ovf;
      if (s) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      else   full = {1'b0, a} + {1'b0, b};
      r = full[W-1:0];
      if (s) ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      else   ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      return {ovf, full[W], r};
   endfunction

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   // ---------------- driver ----------------
   // Called #1 after a rising edge with the DUT in IDLE; returns #1 after the
   // edge following the done pulse (DUT in IDLE again).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input bit abuse);
      logic [W+1:0] exp;
      int           lat;
      exp_q.push_back(model(a, b, s));
      A = a; B = b; sub = s; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("busy_accept", 64'(busy), 64'd1);
      check("cout_clear", 64'(cout), 64'd0);
      check("zero_clear", 64'(zero), 64'd0);
`ifdef ADDSUB_OVERFLOW_EN
      check("ovf_clear", 64'(overflow), 64'd0);
`endif
      // Disturb the inputs; a start pulse here must be ignored.
      A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
      start = abuse;
      lat = 0;
      for (int c = 1; c <= BYTES + 6; c++) begin
         @(posedge clock); #1;
         start = 1'b0;
         A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
         if (done) begin
            lat = c;
            break;
         end
         check("busy_run", 64'(busy), 64'd1);
      end
      check("latency", 64'(lat), 64'(BYTES + 1));
      exp = exp_q.pop_front();
      check("result", 64'(result), 64'(exp[W-1:0]));
      check("cout", 64'(cout), 64'(exp[W]));
      check("zero", 64'(zero), 64'(exp[W-1:0] == '0));
`ifdef ADDSUB_OVERFLOW_EN
      check("overflow", 64'(overflow), 64'(exp[W+1]));
`endif
      @(posedge clock); #1;
      check("done_pulse", 64'(done), 64'd0);
      check("result_hold", 64'(result), 64'(exp[W-1:0]));
      check("cout_hold", 64'(cout), 64'(exp[W]));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int seen_done;
      reset = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_zero", 64'(zero), 64'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      // directed corners
      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
      run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0);
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
      run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
      run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);

      // start during RUN is ignored
      run_op(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b1);

      // reset at the second RUN cycle aborts without a done
      A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D; sub = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_result", 64'(result), 64'd0);
      check("abort_cout", 64'(cout), 64'd0);
      check("abort_zero", 64'(zero), 64'd0);
`ifdef ADDSUB_OVERFLOW_EN
      check("abort_ovf", 64'(overflow), 64'd0);
`endif
      seen_done = 0;
      for (int c = 0; c < BYTES + 4; c++) begin
         @(posedge clock); #1;
         if (done) seen_done++;
      end
      check("abort_no_done", 64'(seen_done), 64'd0);

      // reset and start together: reset wins
      reset = 1'b1; start = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0; start = 1'b0;
      check("rst_start_busy", 64'(busy), 64'd0);
      @(posedge clock); #1;
      check("rst_start_idle", 64'(busy), 64'd0);

      run_op(32'hCAFE_0001, 32'h0000_FFFF, 1'b0, 1'b0);

      // random back-to-back operations
      for (int n = 0; n < 60; n++) begin
         run_op(pick_operand(), pick_operand(), 1'($urandom), ($urandom_range(0, 3) == 0));
      end

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
